// File: rtl/ripple_carry_adder.sv
// Purpose: N-bit ripple-carry adder, s/cout = a + b + cin.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
`timescale 1ns/1ps
module ripple_carry_adder #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/carry_select_adder.sv
// Purpose: unsigned carry-select adder {co,sum} = a + b + ci, plus a registered copy.
// Latency: sum/co combinational; sum_q/co_q one clk later.
// Backpressure: none; registers load on every rising clk, async-cleared by rst.
`timescale 1ns/1ps
module carry_select_adder #(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic [WIDTH-1:0] sum_q,
  output logic             co_q
);

  // Oversized BLOCK collapses to a single ripple adder.
  localparam int BLK  = (BLOCK > WIDTH) ? WIDTH : ((BLOCK < 1) ? 1 : BLOCK);
  localparam int NBLK = (WIDTH + BLK - 1) / BLK;

  // bc[k] is the carry into block k; bc[NBLK] is the final carry out.
  logic [NBLK:0] bc;

  assign bc[0] = ci;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int W  = ((WIDTH - LO) < BLK) ? (WIDTH - LO) : BLK;

    if (k == 0) begin : g_first
      ripple_carry_adder #(.N(W)) u_rca (
        .a    (a[LO +: W]),
        .b    (b[LO +: W]),
        .cin  (bc[0]),
        .s    (sum[LO +: W]),
        .cout (bc[1])
      );
    end else begin : g_sel
      logic [W-1:0] s0;
      logic [W-1:0] s1;
      logic         c0;
      logic         c1;

      ripple_carry_adder #(.N(W)) u_rca0 (
        .a    (a[LO +: W]),
        .b    (b[LO +: W]),
        .cin  (1'b0),
        .s    (s0),
        .cout (c0)
      );

      ripple_carry_adder #(.N(W)) u_rca1 (
        .a    (a[LO +: W]),
        .b    (b[LO +: W]),
        .cin  (1'b1),
        .s    (s1),
        .cout (c1)
      );

      assign sum[LO +: W] = bc[k] ? s1 : s0;
      assign bc[k+1]      = bc[k] ? c1 : c0;
    end
  end

  assign co = bc[NBLK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum;
      co_q  <= co;
    end
  end

endmodule

// File: tb/tb_carry_select_adder.sv
// Directed and exhaustive checks of carry_select_adder at several WIDTH/BLOCK points,
// plus the asynchronous-reset behaviour of the registered copy.
`timescale 1ns/1ps
module tb_carry_select_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a, b, sum, sum_q;
  logic       ci, co, co_q;

  logic [4:0] a5, b5;
  logic       ci5;
  logic [4:0] s52, s51, s55, q52, q51, q55;
  logic       c52, c51, c55, cq52, cq51, cq55;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  carry_select_adder #(.WIDTH(4), .BLOCK(2)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci),
    .sum(sum), .co(co), .sum_q(sum_q), .co_q(co_q)
  );

  carry_select_adder #(.WIDTH(5), .BLOCK(2)) dut52 (
    .clk(clk), .rst(rst), .a(a5), .b(b5), .ci(ci5),
    .sum(s52), .co(c52), .sum_q(q52), .co_q(cq52)
  );

  carry_select_adder #(.WIDTH(5), .BLOCK(1)) dut51 (
    .clk(clk), .rst(rst), .a(a5), .b(b5), .ci(ci5),
    .sum(s51), .co(c51), .sum_q(q51), .co_q(cq51)
  );

  carry_select_adder #(.WIDTH(5), .BLOCK(5)) dut55 (
    .clk(clk), .rst(rst), .a(a5), .b(b5), .ci(ci5),
    .sum(s55), .co(c55), .sum_q(q55), .co_q(cq55)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
    string      name;
  } vec_t;

  vec_t vt[10];

  initial begin
    int n_exh;

    vt[0] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, "f_plus_0_ci"};
    vt[1] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0, "7_plus_8"};
    vt[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "f_plus_f_ci"};
    vt[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, "zero"};
    vt[4] = '{4'h3, 4'h1, 1'b0, 4'h4, 1'b0, "blk_carry"};
    vt[5] = '{4'h3, 4'h1, 1'b1, 4'h5, 1'b0, "blk_carry_ci"};
    vt[6] = '{4'h9, 4'h8, 1'b0, 4'h1, 1'b1, "9_plus_8"};
    vt[7] = '{4'h5, 4'hA, 1'b1, 4'h0, 1'b1, "5_plus_a_ci"};
    vt[8] = '{4'h6, 4'h6, 1'b0, 4'hC, 1'b0, "6_plus_6"};
    vt[9] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, "a_plus_5"};

    // Reset state, before any clock edge; combinational path live under rst.
    a = 4'h9; b = 4'h8; ci = 1'b0;
    a5 = 5'd0; b5 = 5'd0; ci5 = 1'b0;
    #2;
    check("rst_sum_q", int'(sum_q), 0);
    check("rst_co_q", int'(co_q), 0);
    check("rst_q52", int'({cq52, q52}), 0);
    check("rst_q51", int'({cq51, q51}), 0);
    check("rst_q55", int'({cq55, q55}), 0);
    check("rst_comb_sum", int'(sum), 1);
    check("rst_comb_co", int'(co), 1);

    for (int i = 0; i < 10; i++) begin
      a = vt[i].a; b = vt[i].b; ci = vt[i].ci;
      #5;
      check({vt[i].name, "_sum"}, int'(sum), int'(vt[i].s));
      check({vt[i].name, "_co"}, int'(co), int'(vt[i].co));
    end
    check("q_held_in_rst", int'({co_q, sum_q}), 0);

    n_exh = 0;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          a = 4'(x); b = 4'(y); ci = 1'(c);
          #5;
          check("exh_w4b2", int'({co, sum}), x + y + c);
          n_exh++;
        end
    check("exh_count", n_exh, 512);

    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        for (int c = 0; c < 2; c++) begin
          a5 = 5'(x); b5 = 5'(y); ci5 = 1'(c);
          #5;
          check("exh_w5b2", int'({c52, s52}), x + y + c);
          check("exh_w5b1", int'({c51, s51}), x + y + c);
          check("exh_w5b5", int'({c55, s55}), x + y + c);
        end

    // Registered path: release, load, hold, async clear, reload.
    @(negedge clk);
    rst = 1'b0;
    a = 4'h9; b = 4'h8; ci = 1'b0;
    @(posedge clk); #1;
    check("reg_first_sum_q", int'(sum_q), 1);
    check("reg_first_co_q", int'(co_q), 1);

    a = 4'h3; b = 4'h1; ci = 1'b0;
    #1;
    check("reg_hold_sum_q", int'(sum_q), 1);
    check("reg_new_comb", int'({co, sum}), 4);
    @(posedge clk); #1;
    check("reg_second_sum_q", int'(sum_q), 4);
    check("reg_second_co_q", int'(co_q), 0);

    #1;
    a = 4'hF; b = 4'hF; ci = 1'b1; rst = 1'b1;
    #1;
    check("async_clr_sum_q", int'(sum_q), 0);
    check("async_clr_co_q", int'(co_q), 0);
    check("rst_mid_comb_sum", int'(sum), 15);
    check("rst_mid_comb_co", int'(co), 1);
    @(posedge clk); #1;
    check("rst_hold_edge", int'({co_q, sum_q}), 0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reload_sum_q", int'(sum_q), 15);
    check("reload_co_q", int'(co_q), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
